// File: rtl/fetch_pkg.sv
// Shared constants for the fetch pipeline: widths, control types, opcodes, fields.
package fetch_pkg;
    localparam int SIZE_PC     = 32;
    localparam int INST_WIDTH  = 64;
    localparam int FETCH_WIDTH = 4;
    localparam int INST_BYTES  = INST_WIDTH / 8;

    // 2-bit control type reported per slot; non-CTI slots also report CT_JUMP
    typedef enum logic [1:0] {
        CT_RETURN = 2'b00,
        CT_CALL   = 2'b01,
        CT_JUMP   = 2'b10,
        CT_COND   = 2'b11
    } ctrl_type_e;

    localparam logic [7:0] OP_J     = 8'h01;
    localparam logic [7:0] OP_JAL   = 8'h02;
    localparam logic [7:0] OP_JR    = 8'h03;
    localparam logic [7:0] OP_JALR  = 8'h04;
    localparam logic [7:0] OP_BR_LO = 8'h05;
    localparam logic [7:0] OP_BR_HI = 8'h0A;

    // Instruction field bit positions
    localparam int OPC_MSB = 39;
    localparam int OPC_LSB = 32;
    localparam int RS_MSB  = 31;
    localparam int RS_LSB  = 24;
    localparam int TGT_MSB = 25;
    localparam int IMM_MSB = 15;

    localparam logic [7:0] RA_REG = 8'd31;

    // PC of slot idx within a bundle starting at base
    function automatic logic [SIZE_PC-1:0] slot_pc(input logic [SIZE_PC-1:0] base, input int idx);
        return base + SIZE_PC'(idx * INST_BYTES);
    endfunction
endpackage

// File: rtl/fs2_predecode.sv
// Single-slot predecoder: classifies the instruction and computes its static target.
module fs2_predecode
    import fetch_pkg::*;
(
    input  logic [OPC_MSB:0]    inst_i,
    input  logic [SIZE_PC-1:0]  slot_pc_i,
    output logic                is_cti_o,
    output logic [1:0]          ctrl_type_o,
    output logic                is_direct_o,
    output logic                is_return_o,
    output logic [SIZE_PC-1:0]  decoded_target_o
);
    logic [7:0]         opcode;
    logic [7:0]         rs;
    logic [IMM_MSB:0]   imm16;
    logic [TGT_MSB:0]   tgt26;
    logic [SIZE_PC-1:0] br_off;
    logic [SIZE_PC-1:0] fall_thru;

    // Decode type and target; non-CTI defaults to jump type with fall-through target
    always_comb begin
        opcode           = inst_i[OPC_MSB:OPC_LSB];
        rs               = inst_i[RS_MSB:RS_LSB];
        imm16            = inst_i[IMM_MSB:0];
        tgt26            = inst_i[TGT_MSB:0];
        br_off           = {{(SIZE_PC-19){imm16[IMM_MSB]}}, imm16, 3'b000};
        fall_thru        = slot_pc_i + SIZE_PC'(INST_BYTES);
        is_cti_o         = 1'b0;
        ctrl_type_o      = CT_JUMP;
        is_direct_o      = 1'b0;
        is_return_o      = 1'b0;
        decoded_target_o = fall_thru;
        case (opcode)
            OP_J: begin
                is_cti_o         = 1'b1;
                is_direct_o      = 1'b1;
                decoded_target_o = {slot_pc_i[SIZE_PC-1:28], tgt26, 2'b00};
            end
            OP_JAL: begin
                is_cti_o         = 1'b1;
                ctrl_type_o      = CT_CALL;
                is_direct_o      = 1'b1;
                decoded_target_o = {slot_pc_i[SIZE_PC-1:28], tgt26, 2'b00};
            end
            OP_JR: begin
                is_cti_o = 1'b1;
                if (rs == RA_REG) begin
                    ctrl_type_o = CT_RETURN;
                    is_return_o = 1'b1;
                end
            end
            OP_JALR: begin
                is_cti_o    = 1'b1;
                ctrl_type_o = CT_CALL;
            end
            default: begin
                if (opcode >= OP_BR_LO && opcode <= OP_BR_HI) begin
                    is_cti_o         = 1'b1;
                    ctrl_type_o      = CT_COND;
                    decoded_target_o = fall_thru + br_off;
                end
            end
        endcase
    end
endmodule

// File: rtl/fetch_stage2.sv
// Fetch stage 2: registers the stage-1 bundle, predecodes it, verifies stage-1
// predictions and issues ID-level redirect / RAS push / RAS pop to stage 1.
module fetch_stage2
    import fetch_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          stall_i,
    input  logic                          fs1Ready_i,
    input  logic [FETCH_WIDTH*INST_WIDTH-1:0] instructionBundle_i,
    input  logic [SIZE_PC-1:0]            pc_i,
    input  logic [FETCH_WIDTH-1:0]        btbHit_i,
    input  logic [FETCH_WIDTH-1:0]        prediction_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0] targetAddr_i,
    output logic                          flagRecoverID_o,
    output logic [SIZE_PC-1:0]            targetAddrID_o,
    output logic                          flagCallID_o,
    output logic [SIZE_PC-1:0]            callPCID_o,
    output logic                          flagRtrID_o,
    output logic                          fs2Ready_o,
    output logic [FETCH_WIDTH*INST_WIDTH-1:0] instBundle_o,
    output logic [SIZE_PC-1:0]            pc_o,
    output logic [FETCH_WIDTH-1:0]        instValid_o,
    output logic [2*FETCH_WIDTH-1:0]      ctrlType_o,
    output logic [SIZE_PC-1:0]            predNPC_o
);
    logic                                    valid_q, valid_d;
    logic [FETCH_WIDTH-1:0][INST_WIDTH-1:0]  bundle_q, bundle_d;
    logic [SIZE_PC-1:0]                      pc_q, pc_d;
    logic [FETCH_WIDTH-1:0]                  btb_hit_q, btb_hit_d;
    logic [FETCH_WIDTH-1:0]                  pred_q, pred_d;
    logic [FETCH_WIDTH-1:0][SIZE_PC-1:0]     tgt_q, tgt_d;

    logic [FETCH_WIDTH-1:0][SIZE_PC-1:0]     slot_pcs, dec_tgt;
    logic [FETCH_WIDTH-1:0][1:0]             ctype;
    logic [FETCH_WIDTH-1:0]                  is_cti, is_direct, is_return, is_cond, is_indirect, s1_taken;

    logic                                    done, redirect, call, rtr;
    logic [FETCH_WIDTH-1:0]                  mask;
    logic [SIZE_PC-1:0]                      redir_tgt, call_pc, npc;
    logic                                    fire;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
        assign slot_pcs[g] = slot_pc(pc_q, g);

        fs2_predecode u_pd (
            .inst_i           (bundle_q[g][OPC_MSB:0]),
            .slot_pc_i        (slot_pcs[g]),
            .is_cti_o         (is_cti[g]),
            .ctrl_type_o      (ctype[g]),
            .is_direct_o      (is_direct[g]),
            .is_return_o      (is_return[g]),
            .decoded_target_o (dec_tgt[g])
        );

        assign is_cond[g]     = is_cti[g] && (ctype[g] == CT_COND);
        assign is_indirect[g] = is_cti[g] && !is_direct[g] && !is_return[g] && !is_cond[g];
        // Stage 1 treats a hit as taken unless it is a conditional predicted not-taken
        assign s1_taken[g]    = btb_hit_q[g] && (pred_q[g] || !is_cond[g]);
    end

    // Stage register next-state: flush > stall > own redirect (drop wrong path) > load
    always_comb begin
        valid_d   = valid_q;
        bundle_d  = bundle_q;
        pc_d      = pc_q;
        btb_hit_d = btb_hit_q;
        pred_d    = pred_q;
        tgt_d     = tgt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (flagRecoverID_o) begin
            valid_d = 1'b0;
        end else begin
            valid_d   = fs1Ready_i;
            bundle_d  = instructionBundle_i;
            pc_d      = pc_i;
            btb_hit_d = btbHit_i;
            pred_d    = prediction_i;
            tgt_d     = targetAddr_i;
        end
    end

    // Stage register
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            bundle_q  <= '0;
            pc_q      <= '0;
            btb_hit_q <= '0;
            pred_q    <= '0;
            tgt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            bundle_q  <= bundle_d;
            pc_q      <= pc_d;
            btb_hit_q <= btb_hit_d;
            pred_q    <= pred_d;
            tgt_q     <= tgt_d;
        end
    end

    // Scan slots in order; the first slot that redirects or is predicted taken ends the bundle
    always_comb begin
        done      = 1'b0;
        redirect  = 1'b0;
        call      = 1'b0;
        rtr       = 1'b0;
        mask      = '0;
        redir_tgt = '0;
        call_pc   = '0;
        npc       = pc_q + SIZE_PC'(FETCH_WIDTH * INST_BYTES);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!done) begin
                mask[i] = 1'b1;
                if (!is_cti[i] && s1_taken[i]) begin
                    redirect  = 1'b1;
                    redir_tgt = slot_pcs[i] + SIZE_PC'(INST_BYTES);
                    done      = 1'b1;
                end else if (is_direct[i] && (!btb_hit_q[i] || tgt_q[i] != dec_tgt[i])) begin
                    redirect  = 1'b1;
                    redir_tgt = dec_tgt[i];
                    if (ctype[i] == CT_CALL && !btb_hit_q[i]) begin
                        call    = 1'b1;
                        call_pc = slot_pcs[i] + SIZE_PC'(INST_BYTES);
                    end
                    done = 1'b1;
                end else if (is_cond[i] && s1_taken[i] && tgt_q[i] != dec_tgt[i]) begin
                    redirect  = 1'b1;
                    redir_tgt = dec_tgt[i];
                    done      = 1'b1;
                end else if (is_return[i] && !btb_hit_q[i]) begin
                    // Target comes from the RAS in stage 1, so report 0 here
                    redirect = 1'b1;
                    rtr      = 1'b1;
                    done     = 1'b1;
                end else if (is_indirect[i] || s1_taken[i]) begin
                    npc  = tgt_q[i];
                    done = 1'b1;
                end
            end
        end
        if (redirect) npc = redir_tgt;
    end

    // Flags only fire for a live bundle that is actually leaving the stage this cycle
    assign fire            = valid_q && !stall_i && !flush_i;
    assign flagRecoverID_o = fire && redirect;
    assign flagCallID_o    = fire && call;
    assign flagRtrID_o     = fire && rtr;
    assign targetAddrID_o  = flagRecoverID_o ? redir_tgt : '0;
    assign callPCID_o      = flagCallID_o ? call_pc : '0;

    assign fs2Ready_o   = valid_q;
    assign instBundle_o = bundle_q;
    assign pc_o         = pc_q;
    assign instValid_o  = valid_q ? mask : '0;
    assign ctrlType_o   = valid_q ? ctype : '0;
    assign predNPC_o    = valid_q ? npc : '0;
endmodule

// File: tb/tb_fetch_stage2.sv
// Directed bench for fetch_stage2 with hand-computed expectations.
module tb_fetch_stage2;
    logic         clk = 1'b0;
    logic         reset, flush_i, stall_i, fs1Ready_i;
    logic [255:0] instructionBundle_i;
    logic [31:0]  pc_i;
    logic [3:0]   btbHit_i, prediction_i;
    logic [127:0] targetAddr_i;
    logic         flagRecoverID_o, flagCallID_o, flagRtrID_o, fs2Ready_o;
    logic [31:0]  targetAddrID_o, callPCID_o, pc_o, predNPC_o;
    logic [255:0] instBundle_o;
    logic [3:0]   instValid_o;
    logic [7:0]   ctrlType_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage2 dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i),
        .fs1Ready_i(fs1Ready_i), .instructionBundle_i(instructionBundle_i),
        .pc_i(pc_i), .btbHit_i(btbHit_i), .prediction_i(prediction_i),
        .targetAddr_i(targetAddr_i), .flagRecoverID_o(flagRecoverID_o),
        .targetAddrID_o(targetAddrID_o), .flagCallID_o(flagCallID_o),
        .callPCID_o(callPCID_o), .flagRtrID_o(flagRtrID_o), .fs2Ready_o(fs2Ready_o),
        .instBundle_o(instBundle_o), .pc_o(pc_o), .instValid_o(instValid_o),
        .ctrlType_o(ctrlType_o), .predNPC_o(predNPC_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] op, input logic [7:0] rs, input logic [23:0] lo);
        return {24'h0, op, rs, lo};
    endfunction

    localparam logic [63:0] NOP = 64'h0000_0020_0000_0000;

    // Present a bundle on the stage-1 side (called just after a posedge), capture it, retire inputs
    task automatic load(input logic [3:0][63:0] b, input logic [31:0] pc, input logic [3:0] hit,
                        input logic [3:0] pred, input logic [3:0][31:0] tg);
        instructionBundle_i = b;
        pc_i         = pc;
        btbHit_i     = hit;
        prediction_i = pred;
        targetAddr_i = tg;
        fs1Ready_i   = 1'b1;
        @(posedge clk); #1;
        fs1Ready_i   = 1'b0;
    endtask

    logic [3:0][63:0] b;
    logic [3:0][31:0] tg;
    logic [3:0][63:0] call_b;

    initial begin
        reset = 1'b1; flush_i = 1'b0; stall_i = 1'b0; fs1Ready_i = 1'b1;
        instructionBundle_i = '1; pc_i = 32'hFFFF_FFF0; btbHit_i = '1; prediction_i = '1;
        targetAddr_i = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  fs2Ready_o, 0);
        chk("rst_valid",  instValid_o, 0);
        chk("rst_npc",    predNPC_o, 0);
        chk("rst_ctype",  ctrlType_o, 0);
        chk("rst_flags",  {flagRecoverID_o, flagCallID_o, flagRtrID_o}, 0);
        chk("rst_pc",     pc_o, 0);
        @(posedge clk); #1;
        reset = 1'b0; fs1Ready_i = 1'b0;

        // Sequential bundle, no CTIs
        b = {NOP, NOP, NOP, NOP}; tg = '0;
        load(b, 32'h100, 4'b0000, 4'b0000, tg);
        @(negedge clk);
        chk("seq_ready", fs2Ready_o, 1);
        chk("seq_valid", instValid_o, 4'b1111);
        chk("seq_npc",   predNPC_o, 32'h120);
        chk("seq_flags", {flagRecoverID_o, flagCallID_o, flagRtrID_o}, 0);
        chk("seq_ctype", ctrlType_o, 8'hAA);
        chk("seq_pc",    pc_o, 32'h100);
        chk("seq_bundle", instBundle_o[63:0], NOP);

        // Missed call in slot 1: slotPC 0x108, target {0,0x40,00}=0x100, return addr 0x110
        call_b = {NOP, NOP, mk(8'h02, 8'h00, 24'h40), NOP};
        load(call_b, 32'h100, 4'b0000, 4'b0000, tg);
        // wrong-path bundle offered during the redirect cycle
        instructionBundle_i = {NOP, NOP, NOP, NOP}; pc_i = 32'h120; fs1Ready_i = 1'b1;
        @(negedge clk);
        chk("call_rec",    flagRecoverID_o, 1);
        chk("call_tgt",    targetAddrID_o, 32'h100);
        chk("call_flag",   flagCallID_o, 1);
        chk("call_pc",     callPCID_o, 32'h110);
        chk("call_rtr",    flagRtrID_o, 0);
        chk("call_valid",  instValid_o, 4'b0011);
        chk("call_npc",    predNPC_o, 32'h100);
        chk("call_ctype",  ctrlType_o, 8'hA6);
        @(posedge clk); #1; fs1Ready_i = 1'b0;
        @(negedge clk);
        chk("call_drop",   fs2Ready_o, 0);
        chk("call_noflag", flagRecoverID_o, 0);

        // False hit on non-CTI slot 0 at 0x200 -> redirect to 0x208
        tg = '0; tg[0] = 32'h999;
        load({NOP, NOP, NOP, NOP}, 32'h200, 4'b0001, 4'b0001, tg);
        @(negedge clk);
        chk("fh_rec",   flagRecoverID_o, 1);
        chk("fh_tgt",   targetAddrID_o, 32'h208);
        chk("fh_valid", instValid_o, 4'b0001);
        chk("fh_call",  flagCallID_o, 0);
        @(posedge clk); #1;

        // Cond branch slot 2 at 0x300, imm -1: 0x310 + 8 - 8 = 0x310, s1 said 0x500
        tg = '0; tg[2] = 32'h500;
        load({NOP, mk(8'h05, 8'h00, 24'h00FFFF), NOP, NOP}, 32'h300, 4'b0100, 4'b0100, tg);
        @(negedge clk);
        chk("br2_rec",   flagRecoverID_o, 1);
        chk("br2_tgt",   targetAddrID_o, 32'h310);
        chk("br2_valid", instValid_o, 4'b0111);
        chk("br2_ctype", ctrlType_o, 8'hBA);
        @(posedge clk); #1;

        // Same branch in slot 3: 0x318 + 8 - 8 = 0x318
        tg = '0; tg[3] = 32'h500;
        load({mk(8'h0A, 8'h00, 24'h00FFFF), NOP, NOP, NOP}, 32'h300, 4'b1000, 4'b1000, tg);
        @(negedge clk);
        chk("br3_rec",   flagRecoverID_o, 1);
        chk("br3_tgt",   targetAddrID_o, 32'h318);
        chk("br3_valid", instValid_o, 4'b1111);
        @(posedge clk); #1;

        // Correctly predicted taken branch slot 3, imm 2: 0x318 + 8 + 16 = 0x330
        tg = '0; tg[3] = 32'h330;
        load({mk(8'h07, 8'h00, 24'h000002), NOP, NOP, NOP}, 32'h300, 4'b1000, 4'b1000, tg);
        @(negedge clk);
        chk("brok_rec", flagRecoverID_o, 0);
        chk("brok_npc", predNPC_o, 32'h330);
        chk("brok_valid", instValid_o, 4'b1111);

        // Not-taken prediction on a hit branch with bad target: no redirect, sequential
        tg = '0; tg[1] = 32'h999;
        load({NOP, NOP, mk(8'h06, 8'h00, 24'h000010), NOP}, 32'h600, 4'b0010, 4'b0000, tg);
        @(negedge clk);
        chk("brnt_rec", flagRecoverID_o, 0);
        chk("brnt_npc", predNPC_o, 32'h620);

        // Missed return slot 3
        tg = '0;
        load({mk(8'h03, 8'd31, 24'h0), NOP, NOP, NOP}, 32'h400, 4'b0000, 4'b0000, tg);
        @(negedge clk);
        chk("ret_rec",   flagRecoverID_o, 1);
        chk("ret_rtr",   flagRtrID_o, 1);
        chk("ret_tgt",   targetAddrID_o, 0);
        chk("ret_call",  flagCallID_o, 0);
        chk("ret_valid", instValid_o, 4'b1111);
        @(posedge clk); #1;

        // Indirect call slot 1 terminates without redirect
        tg = '0; tg[1] = 32'h777;
        load({NOP, NOP, mk(8'h04, 8'h05, 24'h0), NOP}, 32'h700, 4'b0000, 4'b0000, tg);
        @(negedge clk);
        chk("ind_rec",   flagRecoverID_o, 0);
        chk("ind_valid", instValid_o, 4'b0011);
        chk("ind_npc",   predNPC_o, 32'h777);

        // Direct jump slot 0 hit with correct target {0,0x80,00}=0x200
        tg = '0; tg[0] = 32'h200;
        load({NOP, NOP, NOP, mk(8'h01, 8'h00, 24'h80)}, 32'h500, 4'b0001, 4'b0000, tg);
        @(negedge clk);
        chk("jok_rec",   flagRecoverID_o, 0);
        chk("jok_valid", instValid_o, 4'b0001);
        chk("jok_npc",   predNPC_o, 32'h200);

        // Stall over a missed-call bundle: silent while stalled, one pulse after
        tg = '0;
        load(call_b, 32'h100, 4'b0000, 4'b0000, tg);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stl_rec",   flagRecoverID_o, 0);
            chk("stl_call",  flagCallID_o, 0);
            chk("stl_ready", fs2Ready_o, 1);
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        @(negedge clk);
        chk("stl_fire_rec",  flagRecoverID_o, 1);
        chk("stl_fire_call", flagCallID_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stl_once", flagRecoverID_o, 0);
        chk("stl_empty", fs2Ready_o, 0);

        // Flush together with a redirect: flush wins
        load(call_b, 32'h100, 4'b0000, 4'b0000, tg);
        flush_i = 1'b1; fs1Ready_i = 1'b1;
        @(negedge clk);
        chk("fl_flags", {flagRecoverID_o, flagCallID_o, flagRtrID_o}, 0);
        @(posedge clk); #1;
        flush_i = 1'b0; fs1Ready_i = 1'b0;
        @(negedge clk);
        chk("fl_empty", fs2Ready_o, 0);

        // Reset during a stall clears the stage
        load({NOP, NOP, NOP, NOP}, 32'h800, 4'b0000, 4'b0000, tg);
        stall_i = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rststl_ready", fs2Ready_o, 0);
        chk("rststl_pc",    pc_o, 0);
        reset = 1'b0; stall_i = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
